// File: rtl/rw_atom_array_pkg.sv
// rtl/rw_atom_array_pkg.sv - shared types and operand mux for the read/write atoms
package rw_atom_pkg;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    ADD   = 2'b10,
    CLEAR = 2'b11
  } mode_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest operand the shared mux handles; callers zero-extend in and truncate out.
  localparam int OP_MAX_W = 64;

  function automatic logic [OP_MAX_W-1:0] sel_operand(
    input logic                sel,
    input logic [OP_MAX_W-1:0] constant_val,
    input logic [OP_MAX_W-1:0] pkt_val
  );
    return sel ? pkt_val : constant_val;
  endfunction

endpackage

// File: rtl/rw_atom_array_if.sv
// rtl/rw_atom_array_if.sv - packet-in / result-out bundle of the atom array
// o__sat exists only when RW_ATOM_ARRAY_SAT_EN is defined.
interface rw_atom_array_if
  import rw_atom_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int IDX_WIDTH   = 4
);

  logic                   i__valid;
  logic                   o__ready;
  logic [IDX_WIDTH-1:0]   i__idx;
  mode_t                  i__mode;
  logic [COUNT_WIDTH-1:0] i__constant;
  logic [COUNT_WIDTH-1:0] i__pkt_1;
  logic                   i__sel;
  logic                   o__valid;
  logic [COUNT_WIDTH-1:0] o__old;
  logic [COUNT_WIDTH-1:0] o__new;
  logic                   o__err;
`ifdef RW_ATOM_ARRAY_SAT_EN
  logic                   o__sat;
`endif

  modport master (
    output i__valid, i__idx, i__mode, i__constant, i__pkt_1, i__sel,
    input  o__ready, o__valid, o__old, o__new,
`ifdef RW_ATOM_ARRAY_SAT_EN
    input  o__sat,
`endif
    input  o__err
  );

  modport slave (
    input  i__valid, i__idx, i__mode, i__constant, i__pkt_1, i__sel,
    output o__ready, o__valid, o__old, o__new,
`ifdef RW_ATOM_ARRAY_SAT_EN
    output o__sat,
`endif
    output o__err
  );

endinterface

// File: rtl/rw_atom_array_alu.sv
// rtl/rw_atom_array_alu.sv - combinational update of one state word
// RW_ATOM_ARRAY_SAT_EN selects saturating ADD and adds the sat flag.
module rw_atom_alu
  import rw_atom_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic [COUNT_WIDTH-1:0] old_val,
  input  logic [COUNT_WIDTH-1:0] op,
  input  mode_t                  mode,
`ifdef RW_ATOM_ARRAY_SAT_EN
  output logic                   sat,
`endif
  output logic [COUNT_WIDTH-1:0] new_val
);

`ifdef RW_ATOM_ARRAY_SAT_EN
  logic [COUNT_WIDTH:0] sum;
  assign sum = {1'b0, old_val} + {1'b0, op};
`endif

  always_comb begin
    new_val = old_val;
`ifdef RW_ATOM_ARRAY_SAT_EN
    sat = 1'b0;
`endif
    case (mode)
      READ:  new_val = old_val;
      WRITE: new_val = op;
      ADD: begin
`ifdef RW_ATOM_ARRAY_SAT_EN
        if (sum[COUNT_WIDTH]) begin
          new_val = '1;
          sat     = 1'b1;
        end else begin
          new_val = sum[COUNT_WIDTH-1:0];
        end
`else
        new_val = old_val + op;
`endif
      end
      CLEAR: new_val = '0;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/rw_atom_array.sv
// rtl/rw_atom_array.sv - indexed array of read/write/add/clear state words
// RW_ATOM_ARRAY_SAT_EN: saturating ADD with o__sat result flag.
module rw_atom_array
  import rw_atom_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input logic             clk,
  input logic             rst,
  rw_atom_array_if.slave  bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [IDX_WIDTH:0]   ENTRIES_W = (IDX_WIDTH+1)'(NUM_ENTRIES);

  logic [COUNT_WIDTH-1:0] mem [NUM_ENTRIES];

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   sweep_q, sweep_d;
  logic                   sweep_we;
  logic                   accept;
  logic                   in_range;
  logic [COUNT_WIDTH-1:0] op;
  logic [COUNT_WIDTH-1:0] old_val;
  logic [COUNT_WIDTH-1:0] new_val;
`ifdef RW_ATOM_ARRAY_SAT_EN
  logic                   alu_sat;
`endif

  assign bus.o__ready = (state_q == RUN);
  assign accept       = (state_q == RUN) && bus.i__valid;
  assign in_range     = ({1'b0, bus.i__idx} < ENTRIES_W);
  assign old_val      = in_range ? mem[bus.i__idx] : '0;
  assign op = COUNT_WIDTH'(sel_operand(bus.i__sel,
                                       OP_MAX_W'(bus.i__constant),
                                       OP_MAX_W'(bus.i__pkt_1)));

  rw_atom_alu #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_alu (
    .old_val (old_val),
    .op      (op),
    .mode    (bus.i__mode),
`ifdef RW_ATOM_ARRAY_SAT_EN
    .sat     (alu_sat),
`endif
    .new_val (new_val)
  );

  // INIT walks every entry once, zeroing it, before packets are accepted.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we = 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_WIDTH'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Array has no reset of its own; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem[sweep_q] <= '0;
      end else if (accept && in_range && (bus.i__mode != READ)) begin
        mem[bus.i__idx] <= new_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o__valid <= 1'b0;
      bus.o__old   <= '0;
      bus.o__new   <= '0;
      bus.o__err   <= 1'b0;
`ifdef RW_ATOM_ARRAY_SAT_EN
      bus.o__sat   <= 1'b0;
`endif
    end else begin
      bus.o__valid <= accept;
      if (accept) begin
        bus.o__old <= in_range ? old_val : '0;
        bus.o__new <= in_range ? new_val : '0;
        bus.o__err <= !in_range;
`ifdef RW_ATOM_ARRAY_SAT_EN
        bus.o__sat <= in_range && alu_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rw_atom_array.sv
// tb/tb_rw_atom_array.sv - directed and random checks of rw_atom_array against an array model
module tb_rw_atom_array;
  import rw_atom_pkg::*;

  localparam int CW = 8;
  localparam int N  = 12;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rw_atom_array_if #(.COUNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

  rw_atom_array #(
    .COUNT_WIDTH (CW),
    .NUM_ENTRIES (N),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int fails   = 0;
  int model [N];
  int last_old = 0, last_new = 0, last_err = 0, last_sat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int idx, input mode_t m,
                       input int c, input int p, input logic s);
    bus.i__valid    = v;
    bus.i__idx      = IW'(idx);
    bus.i__mode     = m;
    bus.i__constant = CW'(c);
    bus.i__pkt_1    = CW'(p);
    bus.i__sel      = s;
  endtask

  // Called at a negedge while the block is in RUN; returns at the next negedge.
  task automatic apply(input logic v, input int idx, input mode_t m,
                       input int c, input int p, input logic s);
    int o, old_v, new_v, err_v, sat_v, sum;
    drive(v, idx, m, c, p, s);
    @(posedge clk);
    if (v) begin
      o = s ? p : c;
      old_v = 0; new_v = 0; err_v = 0; sat_v = 0;
      if (idx >= N) begin
        err_v = 1;
      end else begin
        old_v = model[idx];
        case (m)
          READ:  new_v = old_v;
          WRITE: new_v = o;
          ADD: begin
            sum = old_v + o;
`ifdef RW_ATOM_ARRAY_SAT_EN
            if (sum > 255) begin new_v = 255; sat_v = 1; end else new_v = sum;
`else
            new_v = sum % 256;
`endif
          end
          default: new_v = 0;
        endcase
        model[idx] = new_v;
      end
      last_old = old_v; last_new = new_v; last_err = err_v; last_sat = sat_v;
    end
    @(negedge clk);
    check("valid", bus.o__valid, v);
    check("old", bus.o__old, last_old);
    check("new", bus.o__new, last_new);
    check("err", bus.o__err, last_err);
`ifdef RW_ATOM_ARRAY_SAT_EN
    check("sat", bus.o__sat, last_sat);
`endif
  endtask

  task automatic wait_sweep(input string tag);
    int cnt = 0;
    while (!bus.o__ready && cnt < 100) begin
      check({tag, "_init_valid"}, bus.o__valid, 1'b0);
      drive($urandom_range(0, 1), $urandom_range(0, N-1), WRITE, $urandom_range(1, 255), 0, 1'b0);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_sweep_cycles"}, cnt, N);
    check({tag, "_post_valid"}, bus.o__valid, 1'b0);
    drive(1'b0, 0, READ, 0, 0, 1'b0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      apply(1'b1, i, READ, 0, 0, 1'b0);
      check(tag, bus.o__old, model[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = 0;
    drive(1'b0, 0, READ, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.o__valid, 1'b0);
    check("rst_old", bus.o__old, 0);
    check("rst_new", bus.o__new, 0);
    check("rst_err", bus.o__err, 1'b0);
    check("rst_ready", bus.o__ready, 1'b0);
`ifdef RW_ATOM_ARRAY_SAT_EN
    check("rst_sat", bus.o__sat, 1'b0);
`endif
    rst = 1'b0;
    wait_sweep("boot");
    read_all("boot_read_zero");

    apply(1'b1, 3, WRITE, 8'h10, 8'h99, 1'b0);
    check("wr3_new_const", bus.o__new, 8'h10);
    apply(1'b1, 3, ADD, 8'h77, 8'h05, 1'b1);
    check("add3_new_const", bus.o__new, 8'h15);

    apply(1'b1, 0, WRITE, 8'hFE, 0, 1'b0);
    apply(1'b1, 0, ADD, 8'h03, 0, 1'b0);
`ifdef RW_ATOM_ARRAY_SAT_EN
    check("wrap_sat_new", bus.o__new, 8'hFF);
    check("wrap_sat_flag", bus.o__sat, 1'b1);
`else
    check("wrap_new", bus.o__new, 8'h01);
`endif

    apply(1'b1, 1, WRITE, 0, 8'hAA, 1'b1);
    apply(1'b1, 2, WRITE, 8'h55, 0, 1'b0);
    apply(1'b1, 1, CLEAR, 8'h12, 8'h34, 1'b0);
    apply(1'b1, 1, READ, 0, 0, 1'b0);
    check("clr1_read", bus.o__old, 8'h00);
    apply(1'b1, 2, READ, 0, 0, 1'b0);
    check("keep2_read", bus.o__old, 8'h55);
    apply(1'b0, 2, WRITE, 8'h11, 0, 1'b0);

    apply(1'b1, 13, ADD, 8'h20, 0, 1'b0);
    check("oor_err", bus.o__err, 1'b1);
    check("oor_new", bus.o__new, 0);
    apply(1'b1, 15, WRITE, 8'h20, 0, 1'b0);
    read_all("oor_read");

    for (int k = 0; k < 300; k++) begin
      apply(($urandom_range(0, 9) < 7), $urandom_range(0, 15), mode_t'($urandom_range(0, 3)),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    end
    read_all("rand_read");

    drive(1'b1, 5, WRITE, 8'h33, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", bus.o__valid, 1'b0);
    check("midrst_ready", bus.o__ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 0;
    last_old = 0; last_new = 0; last_err = 0; last_sat = 0;
    repeat (4) begin
      check("midinit_valid", bus.o__valid, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("resweep");
    apply(1'b1, 5, READ, 0, 0, 1'b0);
    check("resweep_read5", bus.o__old, 8'h00);
    read_all("resweep_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
